// File: rtl/led_frame_sequencer_pkg.sv
// Shared definitions for the LED frame sequencer and its neighbours.
//   state_t      : sequencer FSM state encoding
//   DEF_ADDR_W   : default pixel buffer address width (shared with the serializer)
//   DEF_PIX_W    : default pixel width, GRB 8:8:8
//   DEF_LATCH_W  : default latch-gap counter width
package led_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_PIX_W   = 24;
    localparam int DEF_LATCH_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DRAIN   = 3'd4,
        LATCH   = 3'd5
    } state_t;

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Pixel buffer read port plus the pixel handshake towards the bit serializer.
//   mem_rd / mem_addr  : one-cycle read strobe and address into the pixel buffer
//   mem_rdata          : read data, valid the cycle after mem_rd
//   px_valid / px_data : pixel offered to the serializer
//   px_ready           : serializer accepts px_data on px_valid && px_ready
//   ser_idle           : serializer has shifted out every accepted bit
// master = sequencer side, slave = buffer/serializer side.
interface led_frame_sequencer_if
    import led_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic              px_valid;
    logic [PIX_W-1:0]  px_data;
    logic              px_ready;
    logic              ser_idle;

    modport master (
        output mem_rd, mem_addr, px_valid, px_data,
        input  mem_rdata, px_ready, ser_idle
    );

    modport slave (
        input  mem_rd, mem_addr, px_valid, px_data,
        output mem_rdata, px_ready, ser_idle
    );
endinterface

// File: rtl/led_frame_sequencer_latch_timer.sv
// Loadable down-counter timing the latch/reset gap after a frame.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (0 is treated as 1)
//   load_val   : gap length in cycles
//   tc         : registered, high for the last cycle of the gap
//   tc_next    : tc will be high in the next cycle (lets the caller register
//                outputs that must line up with tc)
module led_latch_timer #(
    parameter int LATCH_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [LATCH_W-1:0] load_val,
    output logic               tc,
    output logic               tc_next
);
    logic [LATCH_W-1:0] cnt;

    assign tc_next = load ? (load_val <= LATCH_W'(1)) : (cnt == LATCH_W'(2));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            cnt <= (load_val <= LATCH_W'(1)) ? LATCH_W'(1) : load_val;
            tc  <= tc_next;
        end else if (cnt > LATCH_W'(1)) begin
            cnt <= cnt - LATCH_W'(1);
            tc  <= tc_next;
        end else begin
            // Gap finished (or never started): park at zero until the next load.
            cnt <= '0;
            tc  <= 1'b0;
        end
    end
endmodule

// File: rtl/led_frame_sequencer.sv
// Fetches cfg_num_leds pixels from the pixel buffer, hands them in order to the
// LED bit serializer, waits for the serializer to drain, times the latch gap and
// pulses frame_done. Optionally restarts automatically (cfg_continuous).
//   clk, rst_n        : clock, synchronous active-low reset
//   cfg_enable        : block enable; dropping it aborts the frame gracefully
//   cfg_continuous    : restart a new frame after each latch gap
//   cfg_num_leds      : pixels per frame (latched at accept)
//   cfg_latch_cycles  : latch-gap length in cycles (latched at accept, 0 acts as 1)
//   start             : one-cycle frame start pulse
//   busy              : frame accepted and not yet finished
//   frame_done        : one-cycle pulse in the last latch-gap cycle
//   bus               : pixel buffer read port and serializer handshake (master)
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int LATCH_W = DEF_LATCH_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic                  cfg_continuous,
    input  logic [ADDR_W-1:0]     cfg_num_leds,
    input  logic [LATCH_W-1:0]    cfg_latch_cycles,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    led_frame_sequencer_if.master bus
);
    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  num_leds_q;
    logic [LATCH_W-1:0] latch_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [PIX_W-1:0]   px_data_q;
    logic               mem_rd_q;
    logic               px_valid_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               abort_q;
    logic               restart_q;

    // One extra bit so idx+1 compares against num_leds without wrapping.
    logic [ADDR_W:0]    idx_inc;
    logic               abort_now;
    logic               cont;
    logic               latch_load;
    logic               tmr_tc;
    logic               tmr_tc_next;

    assign idx_inc    = {1'b0, idx} + (ADDR_W + 1)'(1);
    assign abort_now  = abort_q || !cfg_enable;
    assign cont       = cfg_continuous && !abort_now;
    assign latch_load = (state == DRAIN) && bus.ser_idle;

    // Strobes are gated by rst_n so they drop in the very cycle reset is applied.
    assign bus.mem_rd   = mem_rd_q & rst_n;
    assign bus.px_valid = px_valid_q & rst_n;
    assign bus.mem_addr = mem_addr_q;
    assign bus.px_data  = px_data_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

    led_latch_timer #(.LATCH_W(LATCH_W)) u_latch_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (latch_load),
        .load_val (latch_q),
        .tc       (tmr_tc),
        .tc_next  (tmr_tc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            num_leds_q   <= '0;
            latch_q      <= '0;
            mem_addr_q   <= '0;
            // NOTE: the pixel register is datapath, but it is cleared anyway so a
            // reset leaves every output at a known zero.
            px_data_q    <= '0;
            mem_rd_q     <= 1'b0;
            px_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (busy_q && !cfg_enable) abort_q <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start && cfg_enable && (cfg_num_leds != '0)) begin
                        num_leds_q <= cfg_num_leds;
                        latch_q    <= cfg_latch_cycles;
                        idx        <= '0;
                        mem_addr_q <= '0;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        abort_q    <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // The read is already on the bus; it always completes.
                    mem_rd_q <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (abort_now) begin
                        state <= DRAIN;
                    end else begin
                        px_data_q  <= bus.mem_rdata;
                        px_valid_q <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.px_ready) begin
                        px_valid_q <= 1'b0;
                        idx        <= idx_inc[ADDR_W-1:0];
                        if (!abort_now && (idx_inc < {1'b0, num_leds_q})) begin
                            mem_addr_q <= idx_inc[ADDR_W-1:0];
                            mem_rd_q   <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.ser_idle) begin
                        state <= LATCH;
                        // A one-cycle gap ends in the very next cycle.
                        if (tmr_tc_next) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= cont;
                            restart_q    <= cont;
                        end
                    end
                end
                LATCH: begin
                    if (tmr_tc) begin
                        if (restart_q) begin
                            idx        <= '0;
                            mem_addr_q <= '0;
                            mem_rd_q   <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tmr_tc_next) begin
                        // frame_done and busy are registered one edge early so
                        // they line up with the last gap cycle.
                        frame_done_q <= 1'b1;
                        busy_q       <= cont;
                        restart_q    <= cont;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
